// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl: sample -> convert -> capture sequencer for a self-timed SAR register chain.
// Optional SAR_SEQ_CTRL_CONTINUOUS_EN: a HOLD handshake with i_start set re-enters SAMPLE directly.
module sar_seq_ctrl #(
  parameter int ADC_RESOLUTION = 10,
  parameter int SAMPLE_CYCLES  = 4,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_sample,
  output logic                      o_sar_rstn,
  output logic [ADC_RESOLUTION:0]   o_setn,
  input  logic [ADC_RESOLUTION-1:0] i_a2d,
  output logic [ADC_RESOLUTION-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready
);

  localparam int SMP_W  = $clog2(SAMPLE_CYCLES + 1);
  localparam int STEP_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STG_W  = $clog2(ADC_RESOLUTION + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAMPLE  = 3'd1;
  localparam logic [2:0] ST_CONVERT = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam logic [SMP_W-1:0]      SMP_LOAD   = SMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [STEP_W-1:0]     STEP_LOAD  = STEP_W'(SETTLE_CYCLES - 1);
  localparam logic [STG_W-1:0]      STAGE_LOAD = STG_W'(ADC_RESOLUTION);
  localparam logic [ADC_RESOLUTION:0] SETN_IDLE = {(ADC_RESOLUTION+1){1'b1}};
  localparam logic [ADC_RESOLUTION:0] STAGE_ONE = {{ADC_RESOLUTION{1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [SMP_W-1:0]  smp_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [STG_W-1:0]  stage_cnt;

  // Every output is assigned only here so the set/clear pins see clean flop outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_busy     <= 1'b0;
      o_sample   <= 1'b0;
      o_sar_rstn <= 1'b0;
      o_setn     <= SETN_IDLE;
      o_data     <= '0;
      o_valid    <= 1'b0;
      smp_cnt    <= '0;
      step_cnt   <= '0;
      stage_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state    <= ST_SAMPLE;
            o_busy   <= 1'b1;
            o_sample <= 1'b1;
            smp_cnt  <= SMP_LOAD;
          end
        end

        ST_SAMPLE: begin
          if (smp_cnt == '0) begin
            state      <= ST_CONVERT;
            o_sample   <= 1'b0;
            o_sar_rstn <= 1'b1;
            stage_cnt  <= STAGE_LOAD;
            step_cnt   <= STEP_LOAD;
          end else begin
            smp_cnt <= smp_cnt - SMP_W'(1);
          end
        end

        // All-ones setn marks a settle cycle; anything else is the one-cycle pulse.
        ST_CONVERT: begin
          if (&o_setn) begin
            if (step_cnt == '0) begin
              o_setn <= ~(STAGE_ONE << stage_cnt);
            end else begin
              step_cnt <= step_cnt - STEP_W'(1);
            end
          end else begin
            o_setn   <= SETN_IDLE;
            step_cnt <= STEP_LOAD;
            if (stage_cnt == '0) begin
              state <= ST_CAPTURE;
            end else begin
              stage_cnt <= stage_cnt - STG_W'(1);
            end
          end
        end

        ST_CAPTURE: begin
          o_data  <= i_a2d;
          o_valid <= 1'b1;
          state   <= ST_HOLD;
        end

        ST_HOLD: begin
          if (o_valid && i_ready) begin
            o_valid    <= 1'b0;
            o_sar_rstn <= 1'b0;
`ifdef SAR_SEQ_CTRL_CONTINUOUS_EN
            if (i_start) begin
              state    <= ST_SAMPLE;
              o_sample <= 1'b1;
              smp_cnt  <= SMP_LOAD;
            end else begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
`else
            state  <= ST_IDLE;
            o_busy <= 1'b0;
`endif
          end
        end

        default: begin
          state      <= ST_IDLE;
          o_busy     <= 1'b0;
          o_sample   <= 1'b0;
          o_sar_rstn <= 1'b0;
          o_setn     <= SETN_IDLE;
          o_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sar_seq_ctrl.md
# sar_seq_ctrl

Synchronous sequencer for the self-timed SAR register chain. Runs each conversion in four steps: it samples, releases the SAR register from reset, and issues one registered active-low set pulse per chain stage from MSB down to the dummy stage 0. It then captures the resulting code and presents it on a valid/ready output port. It sits between the system-side conversion request logic and the SAR register/DAC array.

## Interface
- `ADC_RESOLUTION`, 10: number of result bits; the set vector has `ADC_RESOLUTION+1` bits.
- `SAMPLE_CYCLES`, 4: cycles the sample phase is held; must be ≥1.
- `SETTLE_CYCLES`, 2: DAC/comparator settle cycles before each set pulse; must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk`  in  1  sequencer clock; all outputs registered on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  conversion request; sampled only in IDLE.
- `o_busy`  out  1  high in every state except IDLE.
- `o_sample`  out  1  sample switch enable for the cap array.
- `o_sar_rstn`  out  1  active-low clear to the SAR register.
- `o_setn`  out  ADC_RESOLUTION+1  active-low set per chain stage; at most one bit low at a time.
- `i_a2d`  in  ADC_RESOLUTION  code read back from the SAR register.
- `o_data`  out  ADC_RESOLUTION  captured conversion result.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  result consumer ready.

## Operation
- **Reset values:** state IDLE, `o_busy`=0, `o_sample`=0, `o_sar_rstn`=0, `o_setn`=all ones, `o_data`=0, `o_valid`=0, and all counters 0.
- **States:** IDLE → SAMPLE → CONVERT → CAPTURE → HOLD → IDLE.
- **IDLE:** `o_sar_rstn`=0 (register held clear). If `i_start`=1 → SAMPLE.
- **SAMPLE:** `o_sample`=1 and `o_sar_rstn`=0 for exactly `SAMPLE_CYCLES` cycles, then → CONVERT.
- **CONVERT:**
  - `o_sar_rstn`=1 and `o_sample`=0.
  - Stage index k runs from `ADC_RESOLUTION` down to 0.
  - Each step is `SETTLE_CYCLES` cycles with `o_setn` all ones, followed by 1 cycle with only `o_setn[k]`=0.
  - Pulsing stage k−1 latches the comparator decision for stage k. The stage-0 pulse latches bit 1.
  - After the k=0 pulse → CAPTURE.
- **CAPTURE:** one cycle with `o_setn` all ones, which lets the chain settle. On exit, `o_data` ← `i_a2d` and `o_valid` ← 1, then → HOLD.
- **HOLD:** `o_data` and `o_valid` are held stable. When `o_valid`=1 and `i_ready`=1, `o_valid` clears on the next edge and the state goes to IDLE.
- **Outputs:**
  - `o_setn` and `o_sar_rstn` come directly from flops, with no combinational decode, because they drive asynchronous set/clear pins.
  - `o_setn` is never low while `o_sar_rstn`=0.
- **Boundary conditions:**
  - `i_start` outside IDLE is ignored; it is not queued.
  - `i_ready` outside HOLD has no effect.
  - `i_rst` at any point, including mid-CONVERT, returns immediately to the reset values. A partial result is discarded and never flagged valid.
- **Counters:** the step counter is sized `$clog2(SETTLE_CYCLES+1)` and the stage counter is sized `$clog2(ADC_RESOLUTION+1)`. Neither counter wraps; each reloads on state entry.

## Timing
- Edge E0 is the edge that samples `i_start`=1 in IDLE.
- `o_sample`=1 over [E0, E0+SAMPLE_CYCLES).
- `o_sar_rstn` rises at E0+SAMPLE_CYCLES.
- The stage-k pulse is low over [P_k, P_k+1), where P_k = E0+SAMPLE_CYCLES+(ADC_RESOLUTION−k)(SETTLE_CYCLES+1)+SETTLE_CYCLES.
- `o_valid` rises at E0+SAMPLE_CYCLES+(ADC_RESOLUTION+1)(SETTLE_CYCLES+1)+1. With default parameters this is E0+38.
- Minimum back-to-back period: latency + 1 (handshake) + 1 (IDLE cycle).

## Configuration
- **`SAR_SEQ_CTRL_CONTINUOUS_EN`** defined: on a HOLD handshake with `i_start`=1 in the same cycle, go directly to SAMPLE and skip IDLE. `o_sar_rstn` drops to 0 at the same edge. The period becomes latency + 1.
- **Undefined:** HOLD always returns to IDLE for at least one cycle, and `i_start` is evaluated only there.

## Test plan
- **Single conversion:** defaults, with a behavioural SAR register plus comparator model at analog code 0x2A5 and `i_ready`=1. Pulse `i_start` → `o_valid` at E0+38 with `o_data`=0x2A5. `o_setn` shows 11 single-bit low pulses, ordered bit 10 → 0, spaced 3 cycles apart.
- **Backpressure:** hold `i_ready`=0 for 6 cycles after `o_valid` and toggle `i_start` during that window → `o_valid` and `o_data` stay stable, and no new SAMPLE begins. When `i_ready`=1, `o_valid` drops at the next edge and the state returns to IDLE.
- **Start while busy:** assert `i_start` during CONVERT → no effect on the pulse schedule, and exactly one result is produced.
- **Mid-conversion reset:** assert `i_rst` while `o_setn[5]` is low → same-edge reset values (`o_setn`=0x7FF, `o_sar_rstn`=0, `o_valid`=0). A fresh start after release gives a correct code, e.g. 0x001 → 0x001.
- **Extreme codes:** analog codes 0x000 and 0x3FF → `o_data` 0x000 and 0x3FF. Assert that no `o_setn` bit is ever low while `o_sar_rstn`=0.
- **Continuous mode** (`SAR_SEQ_CTRL_CONTINUOUS_EN`): hold `i_start`=1 and `i_ready`=1 → results at E0+38, E0+77, E0+116 for codes 0x155, 0x2AA, 0x0F0.
